pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Consumer end of the branch/jump select path: receives the 2-bit PC-source select from the branch/jump signal logic, owns the program counter, and drives the instruction-fetch request.
- Sequences the pipeline-flush pulses (IF/ID, ID/EX) and a one-cycle fetch bubble after every redirect.
- Sits between the ID/EX control logic and the instruction memory port in the RISC-V pipeline.

Parameters:
- XLEN, 32, width of PC and target addresses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- pc_sel  input  2  00 = conditional branch taken, 01 = JALR, 10 = JAL, 11 = sequential.
- branch_target  input  XLEN  conditional-branch target.
- jalr_target  input  XLEN  JALR target (rs1 + imm, unmasked).
- jal_target  input  XLEN  JAL target.
- stall  input  1  hazard hold; freezes PC when no redirect is pending.
- fetch_ready  input  1  instruction memory accepts the current request.
- fetch_valid  output  1  fetch request valid.
- fetch_addr  output  XLEN  fetch address (equals pc).
- pc  output  XLEN  current PC register.
- pc_plus4  output  XLEN  pc + 4, modulo 2^XLEN.
- flush_if_id  output  1  registered flush pulse for IF/ID.
- flush_id_ex  output  1  registered flush pulse for ID/EX.
- misaligned  output  1  sticky flag: a redirect target was not 4-byte aligned.
- redirect_count  output  CNT_W  number of redirects taken, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, state=BOOT.
  - fetch_valid=0, flush_if_id=0, flush_id_ex=0, misaligned=0, redirect_count=0.
  - Reset asserted in any state, including SQUASH, aborts immediately; no flush pulse survives.
- States: BOOT, FETCH, SQUASH.
- BOOT:
  - fetch_valid=0; pc_sel is ignored.
  - Unconditionally moves to FETCH on the next edge.
- FETCH (fetch_valid=1, fetch_addr=pc, combinational from the state and PC register):
  - Priority 1, redirect (pc_sel != 11):
    - Target: 00 -> branch_target, 01 -> jalr_target with bit0 cleared, 10 -> jal_target.
    - If bits[1:0] of the selected (post-mask) target != 0: set misaligned=1 (sticky until reset).
    - pc <= target with bits[1:0] forced to 0.
    - Next cycle: flush_if_id=1; flush_id_ex=1 only when pc_sel was 00, else 0.
    - redirect_count increments, saturating at all-ones.
    - state -> SQUASH.
    - stall and fetch_ready are ignored in this cycle; redirect wins.
  - Priority 2, stall=1: pc holds.
  - Priority 3, fetch_ready=1: pc <= pc + 4, wrapping to 0 from 2^XLEN-4.
  - Otherwise: pc holds; the request stays asserted with a stable fetch_addr.
- SQUASH:
  - Exactly one cycle.
  - fetch_valid=0; flush outputs carry the registered pulse from the redirect.
  - pc_sel is ignored, since it comes from a squashed instruction.
  - pc holds. Returns to FETCH.
- Flush pulses are exactly one cycle wide and are 0 in every state other than the SQUASH cycle.
- pc_plus4 is combinational from pc and is valid in every state.
- Back-to-back: a redirect presented on the first FETCH cycle after SQUASH is honoured normally (minimum redirect spacing is 2 cycles).

Test Plan:
- Reset release with RESET_PC=0, fetch_ready=1, pc_sel=11:
  - First cycle after reset: fetch_valid=0 (BOOT).
  - Then fetch_addr = 0, 4, 8, 12 on consecutive cycles; flushes stay 0.
- At pc=0x10, pc_sel=00, branch_target=0x40:
  - Next cycle: flush_if_id=1, flush_id_ex=1, fetch_valid=0, pc=0x40.
  - Following cycle: fetch_addr=0x40, flushes=0, redirect_count=1.
- pc_sel=01, jalr_target=0x101:
  - pc=0x100, flush_if_id=1, flush_id_ex=0, misaligned=0.
- pc_sel=10, jal_target=0x102:
  - pc=0x100, misaligned=1.
  - misaligned stays 1 through 10 further sequential cycles.
- Stall and memory backpressure:
  - stall=1 for 3 cycles at pc=0x20: pc holds at 0x20.
  - stall=1 with pc_sel=10, jal_target=0x80: redirect taken, pc=0x80.
  - fetch_ready=0 for 2 cycles: fetch_addr holds.
- Boundaries:
  - pc=0xFFFF_FFFC with fetch_ready=1 -> pc=0x0.
  - pc_sel=00 during SQUASH: ignored, no second flush.
  - reset_n pulled low mid-SQUASH: all outputs clear immediately, pc=RESET_PC.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the PC, drives fetch requests, and sequences flush/bubble after redirects
module pc_redirect_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       pc_sel,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  jalr_target,
    input  logic [XLEN-1:0]  jal_target,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_addr,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misaligned,
    output logic [CNT_W-1:0] redirect_count
);
    typedef enum logic [1:0] {BOOT, FETCH, SQUASH} state_t;
    state_t          state;
    logic            redirect;
    logic [XLEN-1:0] target;

    assign fetch_valid = state == FETCH;
    assign fetch_addr  = pc;
    assign pc_plus4    = pc + XLEN'(4);

    // Redirect is only meaningful while fetching; JALR target has bit0 cleared before use
    always_comb begin
        redirect = state == FETCH && pc_sel != 2'b11;
        target   = pc_sel == 2'b00 ? branch_target :
                   pc_sel == 2'b01 ? {jalr_target[XLEN-1:1], 1'b0} : jal_target;
    end

    // PC update, one-cycle squash bubble, flush pulses, sticky misalignment and redirect counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            misaligned     <= 1'b0;
            redirect_count <= '0;
        end else begin
            flush_if_id <= redirect;
            flush_id_ex <= redirect && pc_sel == 2'b00;
            case (state)
                BOOT:   state <= FETCH;
                FETCH: begin
                    if (redirect) begin
                        pc             <= {target[XLEN-1:2], 2'b00};
                        misaligned     <= misaligned | (target[1:0] != 2'b00);
                        redirect_count <= &redirect_count ? redirect_count : redirect_count + 1'b1;
                        state          <= SQUASH;
                    end else if (!stall && fetch_ready) begin
                        pc <= pc_plus4;
                    end
                end
                SQUASH: state <= FETCH;
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit against a behavioural model
module tb_pc_redirect_unit;
    logic        clk = 0;
    logic        reset_n = 0;
    logic [1:0]  pc_sel = 2'b11;
    logic [31:0] branch_target = 0, jalr_target = 0, jal_target = 0;
    logic        stall = 0, fetch_ready = 0;
    logic        fetch_valid;
    logic [31:0] fetch_addr, pc, pc_plus4;
    logic        flush_if_id, flush_id_ex, misaligned;
    logic [15:0] redirect_count;

    int tests = 0, fails = 0;

    // behavioural model: "booting" means the cycle right after reset, "bubble" the squash cycle
    logic [31:0] m_pc;
    bit          m_booting, m_bubble, m_f1, m_f2, m_mis;
    int          m_cnt;

    pc_redirect_unit dut (
        .clk(clk), .reset_n(reset_n), .pc_sel(pc_sel),
        .branch_target(branch_target), .jalr_target(jalr_target), .jal_target(jal_target),
        .stall(stall), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_addr(fetch_addr), .pc(pc), .pc_plus4(pc_plus4),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .misaligned(misaligned), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 0; m_booting = 1; m_bubble = 0; m_f1 = 0; m_f2 = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        m_f1 = 0; m_f2 = 0;
        if (m_booting) m_booting = 0;
        else if (m_bubble) m_bubble = 0;
        else if (pc_sel != 2'b11) begin
            t = pc_sel == 0 ? branch_target : pc_sel == 1 ? (jalr_target & ~32'd1) : jal_target;
            if (t % 4 != 0) m_mis = 1;
            m_pc = t - (t % 4);
            m_f1 = 1; m_f2 = pc_sel == 0;
            if (m_cnt < 65535) m_cnt++;
            m_bubble = 1;
        end else if (!stall && fetch_ready) m_pc = m_pc + 32'd4;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] bt, jr, jl, input logic st, rdy);
        pc_sel = s; branch_target = bt; jalr_target = jr; jal_target = jl; stall = st; fetch_ready = rdy;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        tests++; if (fetch_valid !== 0 || pc !== 0 || flush_if_id !== 0 || flush_id_ex !== 0 || misaligned !== 0 || redirect_count !== 0) begin
            fails++; $display("FAIL reset_state: fv=%b pc=%h f=%b%b mis=%b cnt=%0d expected all zero", fetch_valid, pc, flush_if_id, flush_id_ex, misaligned, redirect_count);
        end
        @(posedge clk); #2; reset_n = 1;
        tests++; if (fetch_valid !== 0) begin fails++; $display("FAIL boot_valid: got %b expected 0", fetch_valid); end
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 0, 0, 0, 0, 1);
            tests++; if (fetch_valid !== 1 || fetch_addr !== 32'(4 * i) || flush_if_id !== 0 || flush_id_ex !== 0) begin
                fails++; $display("FAIL seq_fetch[%0d]: fv=%b addr=%h f=%b%b expected fv=1 addr=%h f=00", i, fetch_valid, fetch_addr, flush_if_id, flush_id_ex, 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        drive(2'b11, 0, 0, 0, 0, 1);
        tests++; if (pc !== 32'h10) begin fails++; $display("FAIL pre_branch_pc: got %h expected 10", pc); end
        drive(2'b00, 32'h40, 0, 0, 0, 1);
        tests++; if (flush_if_id !== 1 || flush_id_ex !== 1 || fetch_valid !== 0 || pc !== 32'h40) begin
            fails++; $display("FAIL branch_squash: f=%b%b fv=%b pc=%h expected f=11 fv=0 pc=40", flush_if_id, flush_id_ex, fetch_valid, pc);
        end
        drive(2'b11, 0, 0, 0, 0, 1);
        tests++; if (fetch_addr !== 32'h40 || flush_if_id !== 0 || flush_id_ex !== 0 || redirect_count !== 1 || fetch_valid !== 1) begin
            fails++; $display("FAIL branch_resume: addr=%h f=%b%b cnt=%0d fv=%b expected addr=40 f=00 cnt=1 fv=1", fetch_addr, flush_if_id, flush_id_ex, redirect_count, fetch_valid);
        end
    endtask

    task automatic test_jalr();
        drive(2'b01, 0, 32'h101, 0, 0, 1);
        tests++; if (pc !== 32'h100 || flush_if_id !== 1 || flush_id_ex !== 0 || misaligned !== 0) begin
            fails++; $display("FAIL jalr: pc=%h f=%b%b mis=%b expected pc=100 f=10 mis=0", pc, flush_if_id, flush_id_ex, misaligned);
        end
        drive(2'b11, 0, 0, 0, 0, 1);
    endtask

    task automatic test_jal();
        drive(2'b10, 0, 0, 32'h102, 0, 1);
        tests++; if (pc !== 32'h100 || misaligned !== 1 || flush_id_ex !== 0) begin
            fails++; $display("FAIL jal_misaligned: pc=%h mis=%b fid=%b expected pc=100 mis=1 fid=0", pc, misaligned, flush_id_ex);
        end
        drive(2'b11, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            drive(2'b11, 0, 0, 0, 0, 1);
            tests++; if (misaligned !== 1 || pc !== 32'h100 + 32'(4 * (i + 1))) begin
                fails++; $display("FAIL mis_sticky[%0d]: mis=%b pc=%h expected mis=1 pc=%h", i, misaligned, pc, 32'h100 + 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall();
        drive(2'b10, 0, 0, 32'h20, 0, 1);
        drive(2'b11, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 0, 0, 0, 1, 1);
            tests++; if (pc !== 32'h20 || fetch_valid !== 1) begin fails++; $display("FAIL stall_hold[%0d]: pc=%h fv=%b expected pc=20 fv=1", i, pc, fetch_valid); end
        end
        drive(2'b10, 0, 0, 32'h80, 1, 1);
        tests++; if (pc !== 32'h80 || flush_if_id !== 1) begin fails++; $display("FAIL stall_redirect: pc=%h fif=%b expected pc=80 fif=1", pc, flush_if_id); end
        drive(2'b11, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 0, 0, 0, 0, 0);
            tests++; if (fetch_addr !== 32'h80 || fetch_valid !== 1) begin fails++; $display("FAIL backpressure[%0d]: addr=%h fv=%b expected addr=80 fv=1", i, fetch_addr, fetch_valid); end
        end
    endtask

    task automatic test_wrap();
        drive(2'b10, 0, 0, 32'hFFFF_FFFC, 0, 1);
        tests++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 0) begin fails++; $display("FAIL wrap_setup: pc=%h pc4=%h expected pc=fffffffc pc4=0", pc, pc_plus4); end
        drive(2'b11, 0, 0, 0, 0, 1);
        drive(2'b11, 0, 0, 0, 0, 1);
        tests++; if (pc !== 0 || pc_plus4 !== 4) begin fails++; $display("FAIL wrap: pc=%h pc4=%h expected pc=0 pc4=4", pc, pc_plus4); end
    endtask

    task automatic test_back_to_back();
        drive(2'b00, 32'h200, 0, 0, 0, 1);
        drive(2'b00, 32'h300, 0, 0, 0, 1);
        tests++; if (pc !== 32'h200 || flush_if_id !== 0 || flush_id_ex !== 0 || fetch_valid !== 1) begin
            fails++; $display("FAIL squash_ignore: pc=%h f=%b%b fv=%b expected pc=200 f=00 fv=1", pc, flush_if_id, flush_id_ex, fetch_valid);
        end
        drive(2'b00, 32'h400, 0, 0, 0, 1);
        tests++; if (pc !== 32'h400 || flush_if_id !== 1 || flush_id_ex !== 1) begin
            fails++; $display("FAIL back_to_back: pc=%h f=%b%b expected pc=400 f=11", pc, flush_if_id, flush_id_ex);
        end
        drive(2'b11, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [1:0] s;
        for (int i = 0; i < 300; i++) begin
            s = $urandom_range(0, 3) == 0 ? 2'($urandom_range(0, 2)) : 2'b11;
            drive(s, $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
            tests++; if (pc !== m_pc || fetch_addr !== m_pc || pc_plus4 !== m_pc + 32'd4 || fetch_valid !== (!m_booting && !m_bubble)
                         || flush_if_id !== m_f1 || flush_id_ex !== m_f2 || misaligned !== m_mis || redirect_count !== 16'(m_cnt)) begin
                fails++; $display("FAIL random[%0d]: pc=%h fv=%b f=%b%b mis=%b cnt=%0d expected pc=%h fv=%b f=%b%b mis=%b cnt=%0d", i,
                    pc, fetch_valid, flush_if_id, flush_id_ex, misaligned, redirect_count, m_pc, !m_booting && !m_bubble, m_f1, m_f2, m_mis, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_squash();
        drive(2'b11, 0, 0, 0, 0, 1);
        drive(2'b00, 32'h500, 0, 0, 0, 1);
        tests++; if (flush_if_id !== 1) begin fails++; $display("FAIL squash_entry: fif=%b expected 1", flush_if_id); end
        #2; reset_n = 0; #1;
        model_reset();
        tests++; if (pc !== 0 || fetch_valid !== 0 || flush_if_id !== 0 || flush_id_ex !== 0 || misaligned !== 0 || redirect_count !== 0) begin
            fails++; $display("FAIL reset_mid_squash: pc=%h fv=%b f=%b%b mis=%b cnt=%0d expected all zero", pc, fetch_valid, flush_if_id, flush_id_ex, misaligned, redirect_count);
        end
        @(posedge clk); #2; reset_n = 1;
        drive(2'b11, 0, 0, 0, 0, 1);
        drive(2'b11, 0, 0, 0, 0, 1);
        tests++; if (pc !== 4 || fetch_valid !== 1 || flush_if_id !== 0) begin
            fails++; $display("FAIL post_reset_run: pc=%h fv=%b fif=%b expected pc=4 fv=1 fif=0", pc, fetch_valid, flush_if_id);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr();
        test_jal();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid_squash();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
